// File: rtl/rtoy_pkg.sv
// Shared RISC_toy definitions: opcodes, bubble encoding and fetch FSM states.
// Imported by the fetch stage and its IF/ID register.
package rtoy_pkg;

  localparam int XLEN = 32;

  // 5-bit opcodes, as sliced by decode from INSTR_D[31:27]
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_XOR  = 5'd4;
  localparam logic [4:0] OP_SHL  = 5'd5;
  localparam logic [4:0] OP_SHR  = 5'd6;
  localparam logic [4:0] OP_ADDI = 5'd7;
  localparam logic [4:0] OP_LDI  = 5'd8;
  localparam logic [4:0] OP_J    = 5'd9;
  localparam logic [4:0] OP_JL   = 5'd10;
  localparam logic [4:0] OP_BR   = 5'd11;
  localparam logic [4:0] OP_BRL  = 5'd12;
  localparam logic [4:0] OP_STR  = 5'd13;
  localparam logic [4:0] OP_LDR  = 5'd14;

  localparam logic [XLEN-1:0] BUBBLE_INSTR = 32'h0000_0000;

  typedef enum logic {
    FETCH_BOOT = 1'b0,
    FETCH_RUN  = 1'b1
  } fetch_state_e;

  function automatic logic [XLEN-1:0] pcPlus4(input logic [XLEN-1:0] pc);
    return pc + 32'd4;
  endfunction

endpackage

// File: rtl/fetch_stage_ifid_reg.sv
// IF/ID pipeline register: loads a fetched instruction, holds on stall,
// or collapses to a bubble (zero instruction, VALID_D low).
module ifid_reg
  import rtoy_pkg::*;
(
  input  logic            CLK,
  input  logic            RSTn,
  input  logic            i_load,
  input  logic            i_bubble,
  input  logic [XLEN-1:0] i_instr,
  input  logic [XLEN-1:0] i_pcAdd4,
  output logic [XLEN-1:0] o_instr,
  output logic [XLEN-1:0] o_pcAdd4,
  output logic            o_valid
);

  logic [XLEN-1:0] r_instr;
  logic [XLEN-1:0] r_pcAdd4;
  logic            r_valid;

  // Bubble wins over load so a redirect always kills the slot.
  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_instr  <= BUBBLE_INSTR;
      r_pcAdd4 <= '0;
      r_valid  <= 1'b0;
    end else if (i_bubble) begin
      r_instr  <= BUBBLE_INSTR;
      r_pcAdd4 <= '0;
      r_valid  <= 1'b0;
    end else if (i_load) begin
      r_instr  <= i_instr;
      r_pcAdd4 <= i_pcAdd4;
      r_valid  <= 1'b1;
    end
  end

  assign o_instr  = r_instr;
  assign o_pcAdd4 = r_pcAdd4;
  assign o_valid  = r_valid;

endmodule

// File: rtl/fetch_stage.sv
// RISC_toy IF stage: owns PC_F, issues instruction-memory requests and feeds IF/ID,
// honouring hazard stalls and EX-stage redirects.
module fetch_stage
  import rtoy_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          CNT_W    = 32
) (
  input  logic             CLK,
  input  logic             RSTn,
  input  logic             STALL_F,
  input  logic             REDIR_E,
  input  logic [31:0]      TGT_E,
  output logic             IREQ,
  output logic [29:0]      IADDR,
  input  logic [31:0]      INSTR,
  output logic [31:0]      INSTR_D,
  output logic [31:0]      PCADD4_D,
  output logic             VALID_D,
  output logic [CNT_W-1:0] FETCH_CNT
);

  fetch_state_e    r_state;
  fetch_state_e    w_nextState;
  logic [XLEN-1:0] r_pc;
  logic [XLEN-1:0] w_pcNext;
  logic [XLEN-1:0] w_pcAdd4;
  logic [XLEN-1:0] w_tgtAligned;
  logic            w_load;
  logic            w_bubble;
  logic [CNT_W-1:0] r_cnt;

  assign w_pcAdd4     = pcPlus4(r_pc);
  assign w_tgtAligned = TGT_E & ~32'h0000_0003;

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_state <= FETCH_BOOT;
      r_pc    <= RESET_PC;
    end else begin
      r_state <= w_nextState;
      r_pc    <= w_pcNext;
    end
  end

  // BOOT is a single dead cycle; in RUN a redirect outranks a stall.
  always_comb begin
    w_nextState = r_state;
    w_pcNext    = r_pc;
    w_load      = 1'b0;
    w_bubble    = 1'b0;
    case (r_state)
      FETCH_BOOT: begin
        w_nextState = FETCH_RUN;
        w_bubble    = 1'b1;
      end
      FETCH_RUN: begin
        if (REDIR_E) begin
          w_pcNext = w_tgtAligned;
          w_bubble = 1'b1;
        end else if (!STALL_F) begin
          w_pcNext = w_pcAdd4;
          w_load   = 1'b1;
        end
      end
      default: begin
        w_nextState = FETCH_BOOT;
      end
    endcase
  end

  always_ff @(posedge CLK or negedge RSTn) begin
    if (!RSTn) begin
      r_cnt <= '0;
    end else if (w_load) begin
      r_cnt <= r_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
    end
  end

  ifid_reg u_ifid (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .i_load   (w_load),
    .i_bubble (w_bubble),
    .i_instr  (INSTR),
    .i_pcAdd4 (w_pcAdd4),
    .o_instr  (INSTR_D),
    .o_pcAdd4 (PCADD4_D),
    .o_valid  (VALID_D)
  );

  assign IREQ      = (r_state == FETCH_RUN);
  assign IADDR     = r_pc[31:2];
  assign FETCH_CNT = r_cnt;

endmodule
